decode_pipe: RTL
================

Name: decode_pipe

Overview:
- Parametrised, handshaked successor to the single-byte instruction decoder of the bf8b core.
- Sits between the fetch stage and the execute stage.
- Accepts instruction words over valid/ready and supports a two-word extended-address form for type-3 instructions.
- Emits one registered decoded record per instruction, with full back-pressure and a flush for control-flow redirects.

Parameters:
- INST_W, 8, instruction word width; type field is the top 2 bits; must be >= 6.
- ADDR_W, 12, decoded address width; must be >= INST_W-2.
- CNT_W, 16, width of the decoded-instruction counter (optional feature only).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  drop the partial instruction and the pending output.
- in_valid  in  1  instruction word offered.
- in_ready  out  1  word is accepted when in_valid && in_ready.
- in_data  in  INST_W  instruction word.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  consumer accepts the record.
- inst_type  out  2  instruction class.
- srcdst  out  1  source/destination select.
- ext  out  1  record came from a two-word instruction.
- addr  out  ADDR_W  decoded address.
- inst_count  out  CNT_W  decoded-instruction count (see Optional Feature).

Behaviour:
- Field rules (T = in_data[INST_W-1:INST_W-2]):
  - T=00: srcdst=0, ext=0, addr = zero-extended in_data[INST_W-3:0].
  - T=01 or T=10: srcdst=in_data[INST_W-3], ext=0, addr = zero-extended in_data[INST_W-4:0].
  - T=11 with in_data[INST_W-4]=0: srcdst=in_data[INST_W-3], ext=0, addr=0.
  - T=11 with in_data[INST_W-4]=1: extended form; the next accepted word W2 completes it. srcdst=in_data[INST_W-3], ext=1, addr = {in_data[INST_W-5:0], W2}. This value is 2*INST_W-4 bits wide; it is zero-extended or truncated (upper bits dropped) to ADDR_W.
- States:
  - S_OP: waiting for the first word of an instruction.
  - S_EXT: first word held in internal registers, waiting for W2.
- Transitions:
  - In S_OP, accepting an extended first word moves to S_EXT and produces no output.
  - In S_OP, any other accepted word loads the output register and stays in S_OP.
  - In S_EXT, accepting W2 loads the output register and returns to S_OP.
  - W2 is never decoded as an instruction; any bit pattern is legal for it.
- Handshake:
  - in_ready = !out_valid || out_ready, in both states.
  - out_valid is set on the cycle after the accepting edge, giving 1-cycle latency from the accepting edge of the final word.
  - While out_valid && !out_ready, all output fields are held stable.
  - Simultaneous output drain and input accept in the same cycle sustain 1 instruction/cycle; no bubble.
  - out_valid clears on drain when no new record is loaded.
- Reset (rst_n=0 at a rising edge):
  - state=S_OP; out_valid=0, inst_type=0, srcdst=0, ext=0, addr=0, inst_count=0; in_ready=1 on the cycle after reset.
  - Reset mid-S_EXT discards the held first word.
- Flush (priority: rst_n > flush > handshake):
  - state=S_OP, out_valid=0; data fields keep their values; inst_count is unchanged.
  - An input word offered in the flush cycle is not consumed: in_ready is forced 0 while flush=1.
- in_data is ignored when in_valid=0.

Optional Feature:
- Macro DECODE_PIPE_CNT_EN.
- Defined: inst_count increments by 1 on every output handshake (out_valid && out_ready), wraps modulo 2^CNT_W, and is cleared only by reset.
- Undefined: inst_count is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package bf8b_decode_pkg holds:
  - typedef inst_type_t (2-bit: INST_T0=2'b00, INST_T1=2'b01, INST_T2=2'b10, INST_T3=2'b11).
  - State enum dec_state_t (S_OP, S_EXT).
  - Localparam TYPE_MSB_OFS=2.
- Sub-module decode_out_reg: the ready/valid output register holding {inst_type, srcdst, ext, addr}, with load, drain and flush. The decode FSM stays in decode_pipe.

Test Plan (INST_W=8, ADDR_W=12, out_ready=1 unless stated):
- Send 8'h2A -> next cycle out_valid=1, inst_type=0, srcdst=0, ext=0, addr=12'h02A.
- Send 8'h75 then 8'hE0 back-to-back:
  - first record: type 1, srcdst=1, addr=12'h015;
  - second record: type 3, srcdst=1, ext=0, addr=0;
  - no idle cycle between the two records.
- Send 8'hD3 then 8'hB7:
  - no output after the first word;
  - one record after the second word: type 3, srcdst=0, ext=1, addr=12'h3B7.
- out_ready=0 with 8'h2A then 8'h41 offered -> record 12'h02A held stable and in_ready=0. Raise out_ready -> 8'h41 is accepted and decodes as type 1, srcdst=0, addr=12'h001.
- Send 8'hD3, then in the next cycle assert flush with 8'hB7 offered:
  - state returns to S_OP and 8'hB7 is not consumed;
  - when 8'hB7 is offered again, it decodes as type 2, srcdst=1, addr=12'h017.
  - Repeat using rst_n=0 instead of flush -> all outputs 0.
- DECODE_PIPE_CNT_EN defined, CNT_W=4: decode 17 instructions -> inst_count=1 after wrap. Undefined: inst_count stays 0.

Source files
------------

// File: rtl/bf8b_decode_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// bf8b_decode_pkg : shared types for the bf8b decode pipeline
// Rev 1.0
// ---------------------------------------------------------------
package bf8b_decode_pkg;

  typedef enum logic [1:0] {
    INST_T0 = 2'b00,
    INST_T1 = 2'b01,
    INST_T2 = 2'b10,
    INST_T3 = 2'b11
  } inst_type_t;

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_EXT = 1'b1
  } dec_state_t;

  localparam int TYPE_MSB_OFS = 2;

endpackage
`default_nettype wire

// File: rtl/decode_out_reg.sv
`default_nettype none
// ---------------------------------------------------------------
// decode_out_reg : ready/valid output register for decoded records
// Rev 1.0
// ---------------------------------------------------------------
module decode_out_reg
  import bf8b_decode_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [1:0]        ld_type,
  input  logic              ld_srcdst,
  input  logic              ld_ext,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              out_ready,
  output logic              can_accept,
  output logic              out_valid,
  output logic [1:0]        inst_type,
  output logic              srcdst,
  output logic              ext,
  output logic [ADDR_W-1:0] addr
);

  logic              valid_q, valid_d;
  logic [1:0]        type_q, type_d;
  logic              srcdst_q, srcdst_d;
  logic              ext_q, ext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Flush suppresses acceptance so no word is consumed in that cycle.
  assign can_accept = !flush && (!valid_q || out_ready);

  always_comb begin
    valid_d  = valid_q;
    type_d   = type_q;
    srcdst_d = srcdst_q;
    ext_d    = ext_q;
    addr_d   = addr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d  = 1'b1;
      type_d   = ld_type;
      srcdst_d = ld_srcdst;
      ext_d    = ld_ext;
      addr_d   = ld_addr;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      type_q   <= INST_T0;
      srcdst_q <= 1'b0;
      ext_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      type_q   <= type_d;
      srcdst_q <= srcdst_d;
      ext_q    <= ext_d;
      addr_q   <= addr_d;
    end
  end

  assign out_valid = valid_q;
  assign inst_type = type_q;
  assign srcdst    = srcdst_q;
  assign ext       = ext_q;
  assign addr      = addr_q;

endmodule
`default_nettype wire

// File: rtl/decode_pipe.sv
`default_nettype none
// ---------------------------------------------------------------
// decode_pipe : handshaked bf8b instruction decoder with two-word
// extended-address form. Option macro: DECODE_PIPE_CNT_EN.
// Rev 1.0
// ---------------------------------------------------------------
module decode_pipe
  import bf8b_decode_pkg::*;
#(
  parameter int INST_W = 8,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        inst_type,
  output logic              srcdst,
  output logic              ext,
  output logic [ADDR_W-1:0] addr,
  output logic [CNT_W-1:0]  inst_count
);

  localparam int EXT_W = 2*INST_W - 4;

  dec_state_t        state_q, state_d;
  logic              hold_srcdst_q, hold_srcdst_d;
  logic [INST_W-5:0] hold_hi_q, hold_hi_d;

  logic              accept;
  inst_type_t        word_type;
  logic              load;
  inst_type_t        ld_type;
  logic              ld_srcdst;
  logic              ld_ext;
  logic [ADDR_W-1:0] ld_addr;
  logic [EXT_W-1:0]  ext_full;

  assign accept    = in_valid && in_ready;
  assign word_type = inst_type_t'(in_data[INST_W-1 -: TYPE_MSB_OFS]);
  assign ext_full  = {hold_hi_q, in_data};

  always_comb begin
    state_d       = state_q;
    hold_srcdst_d = hold_srcdst_q;
    hold_hi_d     = hold_hi_q;
    load          = 1'b0;
    ld_type       = word_type;
    ld_srcdst     = in_data[INST_W-3];
    ld_ext        = 1'b0;
    ld_addr       = '0;
    if (flush) begin
      state_d = S_OP;
    end else if (accept) begin
      if (state_q == S_EXT) begin
        // Second word is pure address payload, never decoded.
        load      = 1'b1;
        ld_type   = INST_T3;
        ld_srcdst = hold_srcdst_q;
        ld_ext    = 1'b1;
        ld_addr   = ADDR_W'(ext_full);
        state_d   = S_OP;
      end else if (word_type == INST_T3 && in_data[INST_W-4]) begin
        hold_srcdst_d = in_data[INST_W-3];
        hold_hi_d     = in_data[INST_W-5:0];
        state_d       = S_EXT;
      end else begin
        load = 1'b1;
        case (word_type)
          INST_T0: begin
            ld_srcdst = 1'b0;
            ld_addr   = ADDR_W'(in_data[INST_W-3:0]);
          end
          INST_T1, INST_T2: ld_addr = ADDR_W'(in_data[INST_W-4:0]);
          default:          ld_addr = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_OP;
      hold_srcdst_q <= 1'b0;
      hold_hi_q     <= '0;
    end else begin
      state_q       <= state_d;
      hold_srcdst_q <= hold_srcdst_d;
      hold_hi_q     <= hold_hi_d;
    end
  end

  decode_out_reg #(
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .load       (load),
    .ld_type    (ld_type),
    .ld_srcdst  (ld_srcdst),
    .ld_ext     (ld_ext),
    .ld_addr    (ld_addr),
    .out_ready  (out_ready),
    .can_accept (in_ready),
    .out_valid  (out_valid),
    .inst_type  (inst_type),
    .srcdst     (srcdst),
    .ext        (ext),
    .addr       (addr)
  );

`ifdef DECODE_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && out_valid && out_ready) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign inst_count = cnt_q;
`else
  assign inst_count = '0;
`endif

endmodule
`default_nettype wire
